// File: rtl/mem_responder.sv
// Synthesizable single-outstanding memory responder: captures one request,
// waits WAIT_CYCLES edges, then commits a write or returns read data with a one-cycle ready pulse.
module mem_responder #(
    parameter int ADDR_WIDTH  = 4,
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  ready,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    // Handshake: a request is taken on any IDLE edge with valid=1; inputs are then
    // ignored until the single-cycle ready (with err on out-of-range) has been returned.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state, state_n;
    logic [3:0]            cnt;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  complete;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WIDTH-1:0]      req_wdata;
    logic                  in_range;

    assign state_dbg = state;

    // With zero wait states the request completes at its capture edge, so the
    // live inputs stand in for the latched copy while idle.
    always_comb begin
        req_wr    = wr_q;
        req_addr  = addr_q;
        req_wdata = wdata_q;
        if (state == S_IDLE) begin
            req_wr    = wr_rd;
            req_addr  = addr;
            req_wdata = wdata;
        end
        in_range = ({1'b0, req_addr} < DEPTH_LIM);
    end

    always_comb begin
        state_n  = state;
        complete = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_n  = S_RESP;
                        complete = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_n  = S_RESP;
                    complete = 1'b1;
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            ready <= complete;
            err   <= complete & ~in_range;
            if (state == S_IDLE && valid) begin
                wr_q    <= wr_rd;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (complete) begin
                if (in_range) begin
                    if (req_wr) mem[req_addr] <= req_wdata;
                    else        rdata         <= mem[req_addr];
                end else if (!req_wr) begin
                    rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances cover 1-, 0-, 15- and 4-wait-state
// configurations, including a 12-word part for out-of-range accesses.
module tb_mem_responder;

    logic       clk;
    logic       rst_v   [4];
    logic       valid_v [4];
    logic       wr_v    [4];
    logic [3:0] addr_v  [4];
    logic [7:0] wdata_v [4];
    logic [7:0] rdata_v [4];
    logic       ready_v [4];
    logic       err_v   [4];
    logic [1:0] st_v    [4];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    mem_responder #(.ADDR_WIDTH(4), .WIDTH(8), .DEPTH(16), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst(rst_v[0]), .valid(valid_v[0]), .wr_rd(wr_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0]), .state_dbg(st_v[0]));
    mem_responder #(.ADDR_WIDTH(4), .WIDTH(8), .DEPTH(16), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst_v[1]), .valid(valid_v[1]), .wr_rd(wr_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1]), .state_dbg(st_v[1]));
    mem_responder #(.ADDR_WIDTH(4), .WIDTH(8), .DEPTH(12), .WAIT_CYCLES(15)) u_c (
        .clk(clk), .rst(rst_v[2]), .valid(valid_v[2]), .wr_rd(wr_v[2]), .addr(addr_v[2]),
        .wdata(wdata_v[2]), .rdata(rdata_v[2]), .ready(ready_v[2]), .err(err_v[2]), .state_dbg(st_v[2]));
    mem_responder #(.ADDR_WIDTH(4), .WIDTH(8), .DEPTH(16), .WAIT_CYCLES(4)) u_d (
        .clk(clk), .rst(rst_v[3]), .valid(valid_v[3]), .wr_rd(wr_v[3]), .addr(addr_v[3]),
        .wdata(wdata_v[3]), .rdata(rdata_v[3]), .ready(ready_v[3]), .err(err_v[3]), .state_dbg(st_v[3]));

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: present a request; it is captured on the next edge if the DUT is idle
    task automatic start(input int idx, input logic wr, input logic [3:0] a, input logic [7:0] d);
        valid_v[idx] = 1'b1;
        wr_v[idx]    = wr;
        addr_v[idx]  = a;
        wdata_v[idx] = d;
    endtask

    // Counts edges until ready is seen (bounded)
    task automatic wait_ready(input int idx, output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (ready_v[idx]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: inst %0d no ready within %0d cycles", idx, n);
        end
    endtask

    // Full isolated transaction: returns latency, read data and err, checks pulse width
    task automatic run_txn(input int idx, input logic wr, input logic [3:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd, output logic er);
        start(idx, wr, a, d);
        wait_ready(idx, lat);
        rd = rdata_v[idx];
        er = err_v[idx];
        valid_v[idx] = 1'b0;
        tick();
        check($sformatf("pulse_inst%0d", idx), {31'd0, ready_v[idx]}, 32'd0);
    endtask

    initial begin
        int         lat, n;
        logic [7:0] rd;
        logic       er;
        int         pulses;

        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b1; valid_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
        end

        // Reset with random request noise
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) begin
                valid_v[i] = 1'($urandom_range(0, 1));
                wr_v[i]    = 1'($urandom_range(0, 1));
                addr_v[i]  = 4'($urandom_range(0, 15));
                wdata_v[i] = 8'($urandom_range(0, 255));
            end
            tick();
        end
        check("rst_ready", {31'd0, ready_v[0]}, 32'd0);
        check("rst_err", {31'd0, err_v[0]}, 32'd0);
        check("rst_rdata", {24'd0, rdata_v[0]}, 32'd0);
        check("rst_state", {30'd0, st_v[3]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b0; valid_v[i] = 1'b0;
        end
        tick();

        // WAIT_CYCLES=1: read after reset, then write/read
        run_txn(0, 1'b0, 4'd5, 8'h00, lat, rd, er);
        check("a_rd5_after_rst", {24'd0, rd}, 32'h00);
        run_txn(0, 1'b1, 4'd3, 8'hA5, lat, rd, er);
        check("a_wr_lat", lat, 2);
        check("a_wr_err", {31'd0, er}, 32'd0);
        exp_q.push_back(8'hA5);
        run_txn(0, 1'b0, 4'd3, 8'h00, lat, rd, er);
        check("a_rd_lat", lat, 2);
        check("a_rd_data", {24'd0, rd}, {24'd0, exp_q.pop_front()});
        check("a_rd_err", {31'd0, er}, 32'd0);

        // WAIT_CYCLES=0: back-to-back writes holding valid until ready
        start(1, 1'b1, 4'd0, 8'h10);
        for (int k = 0; k < 4; k++) begin
            wait_ready(1, n);
            check($sformatf("b_b2b_lat%0d", k), n, (k == 0) ? 1 : 2);
            if (k < 3) start(1, 1'b1, 4'(k + 1), 8'(8'h11 + k));
            else       valid_v[1] = 1'b0;
        end
        tick();
        check("b_b2b_end", {31'd0, ready_v[1]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'(8'h10 + k));
            run_txn(1, 1'b0, 4'(k), 8'h00, lat, rd, er);
            check($sformatf("b_rd_lat%0d", k), lat, 1);
            check($sformatf("b_rd_data%0d", k), {24'd0, rd}, {24'd0, exp_q.pop_front()});
        end

        // DEPTH=12, WAIT_CYCLES=15: out-of-range and max wait
        run_txn(2, 1'b1, 4'd7, 8'h3C, lat, rd, er);
        check("c_wr_lat", lat, 16);
        run_txn(2, 1'b1, 4'd13, 8'hFF, lat, rd, er);
        check("c_oor_wr_lat", lat, 16);
        check("c_oor_wr_err", {31'd0, er}, 32'd1);
        run_txn(2, 1'b0, 4'd7, 8'h00, lat, rd, er);
        check("c_rd7_data", {24'd0, rd}, 32'h3C);
        check("c_rd7_err", {31'd0, er}, 32'd0);
        run_txn(2, 1'b0, 4'd13, 8'h00, lat, rd, er);
        check("c_oor_rd_data", {24'd0, rd}, 32'h00);
        check("c_oor_rd_err", {31'd0, er}, 32'd1);
        run_txn(2, 1'b0, 4'd1, 8'h00, lat, rd, er);
        check("c_nowrap_data", {24'd0, rd}, 32'h00);
        check("c_nowrap_err", {31'd0, er}, 32'd0);

        // Drop valid mid-WAIT; response still arrives 15 edges after capture
        start(2, 1'b0, 4'd7, 8'h00);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ready_v[2]) pulses++;
        end
        valid_v[2] = 1'b0;
        wait_ready(2, n);
        check("c_drop_early", pulses, 0);
        check("c_drop_lat", n + 5, 16);
        check("c_drop_data", {24'd0, rdata_v[2]}, 32'h3C);
        tick();
        check("c_drop_pulse", {31'd0, ready_v[2]}, 32'd0);

        // WAIT_CYCLES=4: reset at E0+2 aborts the write
        start(3, 1'b1, 4'd2, 8'h55);
        tick();
        tick();
        rst_v[3] = 1'b1;
        tick();
        rst_v[3]   = 1'b0;
        valid_v[3] = 1'b0;
        pulses = 0;
        if (ready_v[3]) pulses++;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ready_v[3]) pulses++;
        end
        check("d_abort_no_ready", pulses, 0);
        run_txn(3, 1'b0, 4'd2, 8'h00, lat, rd, er);
        check("d_abort_lat", lat, 5);
        check("d_abort_data", {24'd0, rd}, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
